audio_mix_out: RTL
==================

# audio_mix_out

Downstream output stage for the piano / music-box voices. Takes two signed 32-bit voice samples (scratch/piano wave generators), mixes and attenuates them at the codec sample rate, and buffers the results in a small FIFO. It then drains the FIFO into the audio codec's write interface with an `audio_out_allowed` / `write_audio_out` handshake, driving the same sample on both channels.

## Interface
- `CLK_DIV`, default 1042: sample-tick period in clocks (50 MHz / 48 kHz); legal range ≥ 4.
- `FIFO_DEPTH`, default 4: sample FIFO entries; power of 2, ≥ 2.
- `clock`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `voice_a`  in  32: signed sample, voice A.
- `voice_a_en`  in  1: include voice A in the mix.
- `voice_b`  in  32: signed sample, voice B.
- `voice_b_en`  in  1: include voice B in the mix.
- `volume`  in  3: attenuation as an arithmetic right shift by 0–7.
- `mute`  in  1: forces the mixed sample to 0.
- `audio_out_allowed`  in  1: codec FIFO has room.
- `write_audio_out`  out  1: one-cycle write strobe to the codec.
- `left_channel_audio_out`  out  32: sample presented to the codec.
- `right_channel_audio_out`  out  32: always equal to the left channel.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow`  out  1: sticky flag, set when a sample was dropped.

## Operation
- **Tick counter:** counts 0..CLK_DIV-1 and wraps. `tick` is high when the count is CLK_DIV-1.
- **Mix, on the `tick` edge:**
  - s = (voice_a_en ? voice_a : 0) + (voice_b_en ? voice_b : 0), computed in 33-bit signed.
  - s is reduced to 32 bits (see Configuration), then shifted `>>> volume`.
  - If `mute` is high, the result is 0.
  - The result is pushed into the FIFO.
- **Push while full:** the sample is dropped and `overflow` is set. If a pop occurs on the same edge, the push is accepted and the level is unchanged.
- **Overflow clear:** `overflow` is cleared only by `reset`.
- **Drain FSM, 3 states:**
  - IDLE → WRITE when the FIFO is non-empty and `audio_out_allowed` = 1 at the edge. On that edge: the head entry is registered onto both channel outputs, `write_audio_out` is set to 1, and the FIFO is popped.
  - WRITE → GAP unconditionally. `write_audio_out` returns to 0.
  - GAP → IDLE unconditionally.
- **Channel outputs:** hold their last written value until the next write.
- **Ordering:** FIFO order is strictly first-in, first-out. Pointers wrap modulo FIFO_DEPTH.
- **Level:** `fifo_level` = push − pop; range 0..FIFO_DEPTH.
- **Reset (also mid-operation):**
  - Tick counter = 0, FIFO flushed (level 0), state = IDLE.
  - `write_audio_out` = 0, both channel outputs = 0, `overflow` = 0.
  - All of the above are visible the cycle after the reset edge. A write pulse in flight is truncated.

## Timing
- **Push timing:** the sample is captured from inputs present at the tick edge. `fifo_level` reflects the push on the following cycle.
- **Write latency:** `write_audio_out` and the channel data go high one cycle after the cycle in which non-empty ∧ allowed is seen.
- **Strobe width:** exactly one cycle. Writes are spaced at least 3 cycles apart (max 1 sample / 3 clocks, far above the tick rate).
- **Tick-to-codec latency:** with an empty FIFO and `audio_out_allowed` = 1, the tick edge to the `write_audio_out` high cycle is 2 cycles.
- **Dropped handshake:** `audio_out_allowed` falling while in WRITE/GAP has no effect on the current write. It is only sampled in IDLE.

## Configuration
- **`AUDIO_MIX_SAT_EN` defined:** the 33-bit sum saturates to 32-bit signed.
  - Results > 0x7FFFFFFF become 0x7FFFFFFF.
  - Results < 0x80000000 become 0x80000000.
- **Not defined:** the sum is truncated to its low 32 bits (two's-complement wrap). This saves the comparators.
- **Both builds:** attenuation and mute are applied after this step.

## Test plan
All scenarios use CLK_DIV = 8, FIFO_DEPTH = 4, and `AUDIO_MIX_SAT_EN` on unless noted.
- **Basic mix:**
  - Stimulus: voice_a = 0x10000000, voice_b = 0x20000000, both enabled, volume 0, allowed = 1.
  - Response: `write_audio_out` pulses 2 cycles after each tick; both channels = 0x30000000; `fifo_level` returns to 0.
- **Saturation:**
  - a = b = 0x70000000 → 0x7FFFFFFF.
  - a = b = 0x90000000 → 0x80000000.
  - With the macro off, a = b = 0x70000000 → 0xE0000000.
- **Attenuation and enables:**
  - voice_a = 0xFFFFFC00 (−1024), voice_b_en = 0, volume = 2 → 0xFFFFFF00.
  - voice_a_en = 0 and voice_b_en = 0 → 0x00000000.
- **Backpressure and overflow:**
  - Stimulus: allowed = 0 over 5 ticks carrying distinct samples 1..5.
  - Response: `fifo_level` = 4 and `overflow` = 1 after the 5th tick.
  - Then allowed = 1: four strobes carrying 1, 2, 3, 4 in order, each separated by 2 low cycles; `overflow` stays 1.
- **Mute:** mute = 1 with nonzero voices → written samples = 0; `fifo_level` behaves normally.
- **Reset mid-write:**
  - Stimulus: assert reset in the WRITE cycle with 2 entries queued.
  - Response: next cycle `write_audio_out` = 0, channels = 0, `fifo_level` = 0, `overflow` = 0; the first strobe after release follows a full CLK_DIV period.

Source files
------------

// File: rtl/audio_mix_out_if.sv
// Codec write-side handshake for audio_mix_out: the allowed/strobe pair plus both channel samples.
interface audio_mix_out_if;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;

  modport master (
    input  audio_out_allowed,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out
  );

  modport slave (
    output audio_out_allowed,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out
  );
endinterface

// File: rtl/audio_mix_out.sv
// Two-voice mixer/attenuator sampled at the codec rate, buffered in a FIFO and drained to the codec.
// Optional macro AUDIO_MIX_SAT_EN: saturate the 33-bit voice sum instead of wrapping it.
module audio_mix_out #(
  parameter int unsigned CLK_DIV    = 1042,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [31:0]                   voice_a,
  input  logic                          voice_a_en,
  input  logic [31:0]                   voice_b,
  input  logic                          voice_b_en,
  input  logic [2:0]                    volume,
  input  logic                          mute,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  audio_mix_out_if.master               codec
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_q;
  logic               write_q;
  logic [31:0]        data_q;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [31:0]        mem_q [FIFO_DEPTH];

  logic               tick_c;
  logic               full_c;
  logic               pop_c;
  logic               push_c;
  logic [32:0]        sum_c;
  logic signed [31:0] reduced_c;
  logic [31:0]        mix_c;

  // Sample mix: 33-bit sum, reduce to 32 bits, attenuate, then mute
  always_comb begin
    sum_c = (voice_a_en ? {voice_a[31], voice_a} : 33'd0)
          + (voice_b_en ? {voice_b[31], voice_b} : 33'd0);
`ifdef AUDIO_MIX_SAT_EN
    case (sum_c[32:31])
      2'b01:   reduced_c = 32'sh7FFF_FFFF;
      2'b10:   reduced_c = 32'sh8000_0000;
      default: reduced_c = $signed(sum_c[31:0]);
    endcase
`else
    reduced_c = $signed(sum_c[31:0]);
`endif
    mix_c = mute ? 32'd0 : 32'(reduced_c >>> volume);
  end

  // Tick counter, FIFO bookkeeping and sticky overflow
  always_comb begin
    tick_c     = (cnt_q == CNT_W'(CLK_DIV - 1));
    full_c     = (level_q == LVL_W'(FIFO_DEPTH));
    pop_c      = (state_q == ST_IDLE) && (level_q != '0) && codec.audio_out_allowed;
    push_c     = tick_c && (!full_c || pop_c);

    cnt_d      = tick_c ? '0 : cnt_q + CNT_W'(1);
    wr_ptr_d   = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d    = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    overflow_d = overflow_q || (tick_c && full_c && !pop_c);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is flushed by the pointer reset, so the array itself carries no reset
  always_ff @(posedge clock) begin
    if (!reset && push_c) begin
      mem_q[wr_ptr_q] <= mix_c;
    end
  end

  // Drain FSM: a pop in IDLE launches a one-cycle strobe followed by a mandatory gap
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          write_q <= 1'b0;
          if (pop_c) begin
            state_q <= ST_WRITE;
            write_q <= 1'b1;
            data_q  <= mem_q[rd_ptr_q];
          end
        end
        ST_WRITE: begin
          state_q <= ST_GAP;
          write_q <= 1'b0;
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
          write_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          write_q <= 1'b0;
        end
      endcase
    end
  end

  assign codec.write_audio_out         = write_q;
  assign codec.left_channel_audio_out  = data_q;
  assign codec.right_channel_audio_out = data_q;
  assign fifo_level                    = level_q;
  assign overflow                      = overflow_q;

endmodule
